// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : multi_debouncer
// Brief   : N-channel switch debouncer: per-channel synchronizer, STABLE/PENDING
//           debounce FSM, registered rise/fall pulses and selectable one-shot.
// Rev     : 1.0
// ============================================================================
module multi_debouncer #(
  parameter int N_CH        = 4,
  parameter int DELAY_CYC   = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] one_shot,
  output logic            any_event
);

  localparam int            CW         = $clog2(DELAY_CYC + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DELAY_CYC - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      state_t                 state_q;
      logic [CW-1:0]          cnt_q;
      logic                   level_q;
      logic                   rise_q;
      logic                   fall_q;

      // Synchronizer keeps shifting even while the counters are disabled.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], sw[gi]};
        end
      end

      assign s = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          if (!en) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else begin
            case (state_q)
              ST_STABLE: begin
                if (s != level_q) begin
                  if (DELAY_CYC == 1) begin
                    level_q <= s;
                    rise_q  <= s;
                    fall_q  <= ~s;
                  end else begin
                    state_q <= ST_PENDING;
                    cnt_q   <= CW'(1);
                  end
                end
              end
              ST_PENDING: begin
                if (s == level_q) begin
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
                end else if (cnt_q == C_CNT_LAST) begin
                  // Pulse lands in the same cycle the new level becomes visible.
                  level_q <= s;
                  rise_q  <= s;
                  fall_q  <= ~s;
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
                end else begin
                  cnt_q <= cnt_q + CW'(1);
                end
              end
            endcase
          end
        end
      end

      assign level[gi] = level_q;
      assign rise[gi]  = rise_q;
      assign fall[gi]  = fall_q;
    end
  endgenerate

  generate
    if (EDGE_MODE == 0) begin : g_os_rise
      assign one_shot = rise;
    end else if (EDGE_MODE == 1) begin : g_os_fall
      assign one_shot = fall;
    end else begin : g_os_both
      assign one_shot = rise | fall;
    end
  endgenerate

  assign any_event = |one_shot;

endmodule
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : tb_multi_debouncer
// Brief   : Directed + randomized bench for multi_debouncer (three EDGE_MODEs)
//           against a run-length reference model of the debounce rules.
// Rev     : 1.0
// ============================================================================
module tb_multi_debouncer;

  localparam int N_CH        = 4;
  localparam int DELAY_CYC   = 10;
  localparam int SYNC_STAGES = 2;

  logic            clk;
  logic            nrst;
  logic            en;
  logic [N_CH-1:0] sw;
  logic [N_CH-1:0] lvl [3];
  logic [N_CH-1:0] rs  [3];
  logic [N_CH-1:0] fl  [3];
  logic [N_CH-1:0] os  [3];
  logic            ae  [3];

  int n_checks = 0;
  int n_err    = 0;

  multi_debouncer #(.N_CH(N_CH), .DELAY_CYC(DELAY_CYC), .SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(0)) u_dut0 (
    .clk(clk), .nrst(nrst), .en(en), .sw(sw), .level(lvl[0]), .rise(rs[0]), .fall(fl[0]),
    .one_shot(os[0]), .any_event(ae[0]));
  multi_debouncer #(.N_CH(N_CH), .DELAY_CYC(DELAY_CYC), .SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(1)) u_dut1 (
    .clk(clk), .nrst(nrst), .en(en), .sw(sw), .level(lvl[1]), .rise(rs[1]), .fall(fl[1]),
    .one_shot(os[1]), .any_event(ae[1]));
  multi_debouncer #(.N_CH(N_CH), .DELAY_CYC(DELAY_CYC), .SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(2)) u_dut2 (
    .clk(clk), .nrst(nrst), .en(en), .sw(sw), .level(lvl[2]), .rise(rs[2]), .fall(fl[2]),
    .one_shot(os[2]), .any_event(ae[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sw seen SYNC_STAGES edges late, and a per-channel count of
  // consecutive enabled edges on which that delayed value disagreed with level.
  logic [N_CH-1:0] hist [$];
  logic [N_CH-1:0] m_lvl, m_rise, m_fall;
  int              m_run [N_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < SYNC_STAGES; k++) hist.push_back('0);
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N_CH; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [N_CH-1:0] s_old;
    if (!nrst) begin
      model_clear();
      return;
    end
    s_old = hist.pop_front();
    hist.push_back(sw);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!en || s_old[i] == m_lvl[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == DELAY_CYC) begin
          m_lvl[i]  = s_old[i];
          m_rise[i] = s_old[i];
          m_fall[i] = !s_old[i];
          m_run[i]  = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("level", {lvl[2], lvl[1], lvl[0]}, {m_lvl, m_lvl, m_lvl});
    check("rise",  {rs[2], rs[1], rs[0]},    {m_rise, m_rise, m_rise});
    check("fall",  {fl[2], fl[1], fl[0]},    {m_fall, m_fall, m_fall});
    check("os_m0", os[0], m_rise);
    check("os_m1", os[1], m_fall);
    check("os_m2", os[2], m_rise | m_fall);
    check("any",   {ae[2], ae[1], ae[0]}, {|(m_rise | m_fall), |m_fall, |m_rise});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    nrst = 1'b0;
    #1;
    model_clear();
    check("arst_level", {lvl[2], lvl[1], lvl[0]}, 0);
    check("arst_pulse", {rs[2], rs[1], rs[0], fl[2], fl[1], fl[0]}, 0);
    check("arst_os",    {os[2], os[1], os[0], ae[2], ae[1], ae[0]}, 0);
    step();
    step();
    nrst = 1'b1;
  endtask

  initial begin : main
    int hit, cnt_a, cnt_b, cnt_c;
    int hold [N_CH];

    nrst = 1'b0;
    en   = 1'b1;
    sw   = '1;
    model_clear();

    // Switches high through reset: all-ones level appears 12 edges after release.
    do_reset();
    hit = 0; cnt_a = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (hit == 0 && lvl[0] == 4'hF) hit = k;
      if (rs[0] == 4'hF) cnt_a++;
    end
    check("rst_rel_edge", hit, SYNC_STAGES + DELAY_CYC);
    check("rst_rel_rise_cnt", cnt_a, 1);

    // Fast toggling on ch0 is rejected; only the final settle is accepted.
    sw = '0;
    do_reset();
    repeat (14) step();
    cnt_a = 0; cnt_b = 0; hit = 0;
    for (int c = 0; c < 30; c++) begin
      if (c % 3 == 0) sw[0] = !sw[0];
      step();
      if (rs[0][0]) cnt_a++;
      if (fl[0][0]) cnt_b++;
    end
    sw[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rs[0][0]) begin cnt_a++; if (hit == 0) hit = k; end
      if (fl[0][0]) cnt_b++;
    end
    check("tog_rise_cnt", cnt_a, 1);
    check("tog_fall_cnt", cnt_b, 0);
    check("tog_rise_edge", hit, SYNC_STAGES + DELAY_CYC);

    // 9-cycle glitch on ch1 is discarded.
    cnt_a = 0;
    sw[1] = 1'b1;
    for (int k = 0; k < 9; k++) begin step(); if (rs[0][1] || fl[0][1]) cnt_a++; end
    sw[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin step(); if (rs[0][1] || fl[0][1]) cnt_a++; end
    check("glitch9_pulses", cnt_a, 0);
    check("glitch9_level", lvl[0][1], 1'b0);

    // 10-cycle pulse on ch1 is accepted, then released.
    cnt_a = 0; hit = 0;
    sw[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin step(); if (rs[0][1]) cnt_a++; end
    sw[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rs[0][1]) cnt_a++;
      if (fl[0][1] && hit == 0) hit = k;
    end
    check("pulse10_rise_cnt", cnt_a, 1);
    check("pulse10_fall_edge", hit, SYNC_STAGES + DELAY_CYC);

    // Press and release ch2: compare one-shot selection across modes.
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    sw[2] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 15) sw[2] = 1'b0;
      step();
      if (os[1][2]) cnt_a++;
      if (os[2][2]) cnt_b++;
      if (ae[2])    cnt_c++;
    end
    check("mode1_os_cnt", cnt_a, 1);
    check("mode2_os_cnt", cnt_b, 2);
    check("mode2_any_cnt", cnt_c, 2);

    // Reset at cnt=7 of a pending rise on ch3 restarts the whole count.
    sw[3] = 1'b1;
    repeat (9) step();
    do_reset();
    hit = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (lvl[0][3] && hit == 0) hit = k;
    end
    check("rst_mid_pend_edge", hit, SYNC_STAGES + DELAY_CYC);

    // en=0 freezes level while ch0 moves; on re-enable a full delay is needed.
    en = 1'b0;
    cnt_a = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0 || c == 8) sw[0] = 1'b0;
      if (c == 4) sw[0] = 1'b1;
      step();
      if (rs[0][0] || fl[0][0]) cnt_a++;
    end
    check("en0_pulses", cnt_a, 0);
    check("en0_level", lvl[0][0], 1'b1);
    en = 1'b1;
    hit = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (fl[0][0] && hit == 0) hit = k;
    end
    check("en1_fall_edge", hit, DELAY_CYC);

    // Randomized phase: mixed hold lengths straddle the debounce threshold.
    for (int i = 0; i < N_CH; i++) hold[i] = $urandom_range(1, 16);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (hold[i] == 0) begin
          sw[i]   = !sw[i];
          hold[i] = $urandom_range(1, 16);
        end else begin
          hold[i]--;
        end
      end
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
- REQ-001 The module SHALL have parameter N_CH, default 4: number of independent switch channels, 1..32.
- REQ-002 The module SHALL have parameter DELAY_CYC, default 10: consecutive stable cycles required to accept a change, 1..65535.
- REQ-003 The module SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, 2..4.
- REQ-004 The module SHALL have parameter EDGE_MODE, default 0: one_shot source, 0=rising, 1=falling, 2=both.
- REQ-005 The module SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
- REQ-006 The module SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
- REQ-007 The module SHALL have port en, input, 1 bit: global enable for the debounce counters.
- REQ-008 The module SHALL have port sw, input, N_CH bits: raw asynchronous switch inputs.
- REQ-009 The module SHALL have port level, output, N_CH bits: debounced stable level per channel.
- REQ-010 The module SHALL have port rise, output, N_CH bits: one-cycle pulse on an accepted 0->1 change.
- REQ-011 The module SHALL have port fall, output, N_CH bits: one-cycle pulse on an accepted 1->0 change.
- REQ-012 The module SHALL have port one_shot, output, N_CH bits: pulse selected by EDGE_MODE.
- REQ-013 The module SHALL have port any_event, output, 1 bit: OR-reduction of one_shot.

Function
- REQ-014 Each sw bit SHALL pass through its own SYNC_STAGES-deep flip-flop chain; the last stage is s[i].
- REQ-015 Each channel SHALL contain an independent two-state FSM (STABLE, PENDING) and a counter cnt of width clog2(DELAY_CYC+1).
- REQ-016 In STABLE with en=1 and s[i]!=level[i], the FSM SHALL go to PENDING with cnt<=1, except when DELAY_CYC=1, where level[i] SHALL update directly.
- REQ-017 In PENDING with s[i]==level[i], the FSM SHALL return to STABLE with cnt<=0 and no pulse.
- REQ-018 In PENDING with s[i]!=level[i]: if cnt==DELAY_CYC-1, then level[i]<=s[i], cnt<=0, state<=STABLE; otherwise cnt<=cnt+1.
- REQ-019 level[i] SHALL change exactly SYNC_STAGES+DELAY_CYC clock edges after sw[i] settles, provided en=1 throughout.
- REQ-020 rise[i]/fall[i] SHALL be registered and asserted for exactly the one cycle in which level[i] first shows the new value.
- REQ-021 one_shot[i] SHALL equal rise[i] (EDGE_MODE=0), fall[i] (EDGE_MODE=1) or rise[i]|fall[i] (EDGE_MODE=2).
- REQ-022 any_event SHALL be combinational from one_shot, with zero added latency.
- REQ-023 A change shorter than DELAY_CYC consecutive synchronized cycles SHALL be discarded, with no level change and no pulse.
- REQ-024 When en=0, every FSM SHALL be forced to STABLE with cnt=0 and no pulses; level SHALL hold and the synchronizers SHALL keep running.
- REQ-025 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.
- REQ-026 The counter SHALL never wrap: it is bounded by DELAY_CYC-1.

Reset
- REQ-027 While nrst=0, synchronizer flops, level, rise, fall, one_shot and cnt SHALL be 0 and every FSM SHALL be STABLE, immediately and without a clock.
- REQ-028 Reset asserted mid-PENDING SHALL abort the count; after release, a pending input SHALL need a full SYNC_STAGES+DELAY_CYC cycles to be accepted.
- REQ-029 A channel whose sw=1 when reset releases SHALL report level=1 only after SYNC_STAGES+DELAY_CYC cycles, with a rise pulse.

Verification (N_CH=4, DELAY_CYC=10, SYNC_STAGES=2, en=1 unless stated)
- REQ-030 Drive sw=4'b1111 during reset, then release -> outputs 0 during reset; level=4'hF at edge 12 after release; rise=4'hF for one cycle only.
- REQ-031 Toggle sw[0] every 3 cycles for 30 cycles, then hold at 1 -> exactly one rise[0] pulse, 12 edges after the final transition; fall[0] never asserted.
- REQ-032 Drive a 9-cycle high glitch on sw[1] -> level[1]=0 with no pulse; repeat with a 10-cycle high -> level[1]=1 and a rise[1] pulse, then a fall[1] pulse 12 edges after release.
- REQ-033 Use EDGE_MODE=2 and press/release sw[2] -> one_shot[2] and any_event pulse twice; with EDGE_MODE=1 -> only on release.
- REQ-034 Assert nrst at cnt=7 of a pending rise on sw[3] -> outputs 0 asynchronously; after release, level[3] rises 12 edges later, not 5.
- REQ-035 Set en=0 while sw[0] is changing -> no level change or pulse; after en=1, the change is accepted after a full DELAY_CYC cycles.
